// File: rtl/alu_rr_sched.sv
// alu_rr_sched: round-robin scheduler sharing one combinational 8-bit ALU
// between NREQ requesters. The winning request is steered onto the ALU
// inputs and the ALU result is captured in a single-entry response register
// tagged with the requester index.
module alu_rr_sched #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [8*NREQ-1:0]   req_a,
  input  logic [8*NREQ-1:0]   req_b,
  input  logic [4*NREQ-1:0]   req_op,
  output logic [7:0]          alu_a,
  output logic [7:0]          alu_b,
  output logic [3:0]          alu_opcode,
  input  logic [7:0]          alu_y,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [7:0]          rsp_y,
  output logic [IDW-1:0]      rsp_id,
  output logic                rsp_err,
  output logic                rsp_zero
);

  localparam int unsigned     NREQ_U   = NREQ;
  // After reset the pointer sits on the last index so requester 0 wins first.
  localparam logic [IDW-1:0]  LAST_RST = IDW'(NREQ - 1);

  // Index reached by stepping 'off' positions past 'base', wrapping modulo
  // NREQ. base < NREQ and off <= NREQ, so one conditional subtract suffices.
  function automatic logic [IDW-1:0] rr_index(input logic [IDW-1:0] base,
                                              input int unsigned    off);
    int unsigned sum;
    sum = 32'(base) + off;
    if (sum >= NREQ_U) begin
      sum = sum - NREQ_U;
    end else begin
      sum = sum;
    end
    return IDW'(sum);
  endfunction

  // Opcodes above 0xB are undefined for the shared ALU.
  function automatic logic op_illegal(input logic [3:0] op);
    return (op > 4'hB);
  endfunction

  // Response register and round-robin pointer.
  logic [IDW-1:0] last_q,      last_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic [7:0]     rsp_y_q,     rsp_y_d;
  logic [IDW-1:0] rsp_id_q,    rsp_id_d;
  logic           rsp_err_q,   rsp_err_d;
  logic           rsp_zero_q,  rsp_zero_d;

  // Combinational arbitration results.
  logic           slot_free_s;
  logic           grant_found_s;
  logic [IDW-1:0] grant_idx_s;
  logic           accept_s;

  // The response slot can take a new result when empty or being drained now.
  always_comb begin
    slot_free_s = !rsp_valid_q || rsp_ready;
  end

  // Round-robin search starting just after the last granted index. When no
  // request is pending the index defaults to last+1, which also selects the
  // (don't-care) ALU operands in the idle case.
  always_comb begin
    grant_found_s = 1'b0;
    grant_idx_s   = rr_index(last_q, 32'd1);
    for (int unsigned k = 1; k <= NREQ_U; k++) begin
      if (!grant_found_s && req_valid[rr_index(last_q, k)]) begin
        grant_found_s = 1'b1;
        grant_idx_s   = rr_index(last_q, k);
      end else begin
        grant_found_s = grant_found_s;
      end
    end
  end

  // A grant is only issued while the response slot can absorb the result.
  always_comb begin
    accept_s = grant_found_s && slot_free_s;
  end

  // One-hot ready towards the winner; all zero when nothing is accepted.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (accept_s && (IDW'(i) == grant_idx_s)) begin
        req_ready[i] = 1'b1;
      end else begin
        req_ready[i] = 1'b0;
      end
    end
  end

  // Steer the selected requester's operands and opcode onto the shared ALU.
  always_comb begin
    alu_a      = 8'h00;
    alu_b      = 8'h00;
    alu_opcode = 4'h0;
    for (int i = 0; i < NREQ; i++) begin
      if (IDW'(i) == grant_idx_s) begin
        alu_a      = req_a[8*i +: 8];
        alu_b      = req_b[8*i +: 8];
        alu_opcode = req_op[4*i +: 4];
      end else begin
        alu_a      = alu_a;
        alu_b      = alu_b;
        alu_opcode = alu_opcode;
      end
    end
  end

  // Next-state for the response register and pointer. An accept overrides a
  // simultaneous drain, so the slot stays full with the newer result.
  always_comb begin
    last_d      = last_q;
    rsp_valid_d = rsp_valid_q;
    rsp_y_d     = rsp_y_q;
    rsp_id_d    = rsp_id_q;
    rsp_err_d   = rsp_err_q;
    rsp_zero_d  = rsp_zero_q;
    if (accept_s) begin
      rsp_valid_d = 1'b1;
      rsp_y_d     = alu_y;
      rsp_id_d    = grant_idx_s;
      rsp_err_d   = op_illegal(alu_opcode);
      rsp_zero_d  = (alu_y == 8'h00);
      last_d      = grant_idx_s;
    end else if (rsp_valid_q && rsp_ready) begin
      rsp_valid_d = 1'b0;
    end else begin
      rsp_valid_d = rsp_valid_q;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q      <= LAST_RST;
      rsp_valid_q <= 1'b0;
      rsp_y_q     <= 8'h00;
      rsp_id_q    <= '0;
      rsp_err_q   <= 1'b0;
      rsp_zero_q  <= 1'b0;
    end else begin
      last_q      <= last_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_y_q     <= rsp_y_d;
      rsp_id_q    <= rsp_id_d;
      rsp_err_q   <= rsp_err_d;
      rsp_zero_q  <= rsp_zero_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_y     = rsp_y_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_zero  = rsp_zero_q;

endmodule

// File: tb/tb_alu_rr_sched.sv
// Directed testbench for alu_rr_sched with a behavioural stand-in for the
// shared ALU and hand-computed expected responses.
module tb_alu_rr_sched;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [15:0] req_op;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [3:0]  alu_opcode;
  logic [7:0]  alu_y;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [7:0]  rsp_y;
  logic [1:0]  rsp_id;
  logic        rsp_err;
  logic        rsp_zero;

  int checks = 0;
  int errors = 0;

  alu_rr_sched #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_opcode (alu_opcode),
    .alu_y      (alu_y),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_y      (rsp_y),
    .rsp_id     (rsp_id),
    .rsp_err    (rsp_err),
    .rsp_zero   (rsp_zero)
  );

  always #5 clk = ~clk;

  // External ALU stand-in: 12 defined opcodes, everything else gives zero.
  always_comb begin
    case (alu_opcode)
      4'h0:    alu_y = alu_a + alu_b;
      4'h1:    alu_y = alu_a - alu_b;
      4'h2:    alu_y = alu_a & alu_b;
      4'h3:    alu_y = alu_a | alu_b;
      4'h4:    alu_y = alu_a ^ alu_b;
      4'h5:    alu_y = ~alu_a;
      4'h6:    alu_y = alu_a << 1;
      4'h7:    alu_y = alu_a >> 1;
      4'h8:    alu_y = alu_a;
      4'h9:    alu_y = alu_b;
      4'hA:    alu_y = alu_a + 8'h01;
      4'hB:    alu_y = alu_a - 8'h01;
      default: alu_y = 8'h00;
    endcase
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b,
                         input logic [3:0] op);
    req_a[8*i +: 8]  = a;
    req_b[8*i +: 8]  = b;
    req_op[4*i +: 4] = op;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    req_valid = 4'h0;
    req_a     = 32'h0;
    req_b     = 32'h0;
    req_op    = 16'h0;
    rsp_ready = 1'b0;
    repeat (2) step();
    checks++;
    if ({rsp_valid, rsp_y, rsp_id, rsp_err, rsp_zero} !== 13'h0) begin
      errors++;
      $display("FAIL reset_outputs got v=%b y=%h id=%0d err=%b zero=%b exp all zero",
               rsp_valid, rsp_y, rsp_id, rsp_err, rsp_zero);
    end
    checks++;
    if (req_ready !== 4'h0) begin
      errors++;
      $display("FAIL reset_idle_ready got %b exp 0000", req_ready);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic_add();
    set_req(0, 8'h05, 8'h03, 4'h0);
    req_valid = 4'b0001;
    rsp_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL basic_ready got %b exp 0001", req_ready);
    end
    step();
    checks++;
    if ({rsp_valid, rsp_y, rsp_id, rsp_err, rsp_zero} !== {1'b1, 8'h08, 2'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL basic_rsp got v=%b y=%h id=%0d err=%b zero=%b exp v=1 y=08 id=0 err=0 zero=0",
               rsp_valid, rsp_y, rsp_id, rsp_err, rsp_zero);
    end
    req_valid = 4'b0000;
    step();
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_drain got v=%b exp 0", rsp_valid);
    end
  endtask

  // Pointer is at 0 after the basic test, so the rotation starts at 1.
  task automatic test_round_robin();
    int exp_id;
    for (int i = 0; i < NREQ; i++) set_req(i, 8'hF0 | 8'(i), 8'h0F, 4'h2);
    req_valid = 4'hF;
    rsp_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      exp_id = (k + 1) % NREQ;
      #1;
      checks++;
      if (req_ready !== (4'b0001 << exp_id)) begin
        errors++;
        $display("FAIL rr_ready k=%0d got %b exp %b", k, req_ready, 4'b0001 << exp_id);
      end
      step();
      checks++;
      if ({rsp_valid, rsp_y, rsp_id, rsp_zero} !==
          {1'b1, 8'(exp_id), 2'(exp_id), (exp_id == 0)}) begin
        errors++;
        $display("FAIL rr_rsp k=%0d got v=%b y=%h id=%0d zero=%b exp y=%h id=%0d",
                 k, rsp_valid, rsp_y, rsp_id, rsp_zero, 8'(exp_id), exp_id);
      end
    end
  endtask

  task automatic test_backpressure();
    step();
    checks++;
    if ({rsp_y, rsp_id} !== {8'h01, 2'd1}) begin
      errors++;
      $display("FAIL bp_first got y=%h id=%0d exp y=01 id=1", rsp_y, rsp_id);
    end
    rsp_ready = 1'b0;
    #1;
    checks++;
    if (req_ready !== 4'b0000) begin
      errors++;
      $display("FAIL bp_ready_low got %b exp 0000", req_ready);
    end
    for (int k = 0; k < 2; k++) begin
      step();
      checks++;
      if ({rsp_valid, rsp_y, rsp_id} !== {1'b1, 8'h01, 2'd1}) begin
        errors++;
        $display("FAIL bp_hold k=%0d got v=%b y=%h id=%0d exp v=1 y=01 id=1",
                 k, rsp_valid, rsp_y, rsp_id);
      end
    end
    rsp_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin
      errors++;
      $display("FAIL bp_release_ready got %b exp 0100", req_ready);
    end
    step();
    checks++;
    if ({rsp_valid, rsp_y, rsp_id} !== {1'b1, 8'h02, 2'd2}) begin
      errors++;
      $display("FAIL bp_no_bubble got v=%b y=%h id=%0d exp v=1 y=02 id=2",
               rsp_valid, rsp_y, rsp_id);
    end
    req_valid = 4'b0000;
    step();
  endtask

  task automatic test_illegal_op();
    set_req(0, 8'hFF, 8'h00, 4'hC);
    req_valid = 4'b0001;
    step();
    checks++;
    if ({rsp_valid, rsp_y, rsp_id, rsp_err, rsp_zero} !== {1'b1, 8'h00, 2'd0, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL illegal_rsp got v=%b y=%h id=%0d err=%b zero=%b exp v=1 y=00 id=0 err=1 zero=1",
               rsp_valid, rsp_y, rsp_id, rsp_err, rsp_zero);
    end
    set_req(0, 8'h00, 8'h01, 4'h1);
    step();
    checks++;
    if ({rsp_valid, rsp_y, rsp_err, rsp_zero} !== {1'b1, 8'hFF, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL sub_rsp got v=%b y=%h err=%b zero=%b exp v=1 y=ff err=0 zero=0",
               rsp_valid, rsp_y, rsp_err, rsp_zero);
    end
    req_valid = 4'b0000;
    step();
  endtask

  task automatic test_fairness_dropout();
    logic [1:0] exp_ids [4];
    exp_ids[0] = 2'd1; exp_ids[1] = 2'd3; exp_ids[2] = 2'd1; exp_ids[3] = 2'd1;
    set_req(1, 8'hF1, 8'h0F, 4'h2);
    set_req(3, 8'hF3, 8'h0F, 4'h2);
    req_valid = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      if (k == 2) req_valid = 4'b0010;
      step();
      checks++;
      if ({rsp_y, rsp_id} !== {6'h0, exp_ids[k], exp_ids[k]}) begin
        errors++;
        $display("FAIL fair_grant k=%0d got y=%h id=%0d exp id=%0d", k, rsp_y, rsp_id, exp_ids[k]);
      end
    end
    req_valid = 4'b1010;
    #1;
    checks++;
    if (req_ready !== 4'b1000) begin
      errors++;
      $display("FAIL fair_reassert_ready got %b exp 1000", req_ready);
    end
    step();
    checks++;
    if ({rsp_y, rsp_id} !== {8'h03, 2'd3}) begin
      errors++;
      $display("FAIL fair_reassert got y=%h id=%0d exp y=03 id=3", rsp_y, rsp_id);
    end
  endtask

  task automatic test_reset_mid();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({rsp_valid, rsp_y, rsp_id, rsp_err, rsp_zero} !== 13'h0) begin
      errors++;
      $display("FAIL midreset_async got v=%b y=%h id=%0d err=%b zero=%b exp all zero",
               rsp_valid, rsp_y, rsp_id, rsp_err, rsp_zero);
    end
    step();
    rst_n = 1'b1;
    for (int i = 0; i < NREQ; i++) set_req(i, 8'hF0 | 8'(i), 8'h0F, 4'h2);
    req_valid = 4'hF;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL midreset_ready got %b exp 0001", req_ready);
    end
    step();
    checks++;
    if ({rsp_valid, rsp_y, rsp_id, rsp_zero} !== {1'b1, 8'h00, 2'd0, 1'b1}) begin
      errors++;
      $display("FAIL midreset_first got v=%b y=%h id=%0d zero=%b exp v=1 y=00 id=0 zero=1",
               rsp_valid, rsp_y, rsp_id, rsp_zero);
    end
    step();
    checks++;
    if ({rsp_y, rsp_id} !== {8'h01, 2'd1}) begin
      errors++;
      $display("FAIL midreset_second got y=%h id=%0d exp y=01 id=1", rsp_y, rsp_id);
    end
  endtask

  initial begin
    test_reset();
    test_basic_add();
    test_round_robin();
    test_backpressure();
    test_illegal_op();
    test_fairness_dropout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
